// File: rtl/rice_stream_reader.sv
// Serial Rice/Golomb codeword reader: unary quotient then k-bit remainder.
// One bit per enabled clock, MSB-first, one-cycle done strobe per codeword.
module rice_stream_reader #(
  parameter int MSB_W   = 16,
  parameter int LSB_W   = 16,
  parameter int PARAM_W = 4
) (
  input  logic               iClock,
  input  logic               iReset,
  input  logic               iEnable,
  input  logic               iData,
  input  logic [PARAM_W-1:0] iRiceParam,
  output logic [MSB_W-1:0]   oMSB,
  output logic [LSB_W-1:0]   oLSB,
  output logic               oDone
);

  typedef enum logic {UNARY, REM} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [MSB_W-1:0]   zcnt;
  logic [LSB_W-1:0]   acc;
  logic [LSB_W-1:0]   acc_nxt;
  logic [PARAM_W-1:0] bcnt;
  logic [PARAM_W-1:0] kreg;
  logic               term;
  logic               fin_rem;
  logic               done_nxt;

  always_ff @(posedge iClock) begin
    if (iReset) state <= UNARY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (iEnable) begin
      unique case (1'b1)
        state == UNARY:
          if (iData && iRiceParam != '0)
            state_nxt = REM;
        state == REM:
          if (fin_rem)
            state_nxt = UNARY;
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    term     = iEnable && (state == UNARY) && iData;
    acc_nxt  = {acc[LSB_W-2:0], iData};
    fin_rem  = iEnable && (state == REM)
               && ((bcnt + PARAM_W'(1)) == kreg);
    done_nxt = (term && iRiceParam == '0) || fin_rem;
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      zcnt  <= '0;
      acc   <= '0;
      bcnt  <= '0;
      kreg  <= '0;
      oMSB  <= '0;
      oLSB  <= '0;
      oDone <= 1'b0;
    end else begin
      oDone <= done_nxt;
      if (iEnable) begin
        if (state == UNARY) begin
          if (!iData) begin
            // quotient saturates rather than wrapping
            if (zcnt != '1)
              zcnt <= zcnt + MSB_W'(1);
          end else if (iRiceParam == '0) begin
            oMSB <= zcnt;
            oLSB <= '0;
            zcnt <= '0;
          end else begin
            kreg <= iRiceParam;
            acc  <= '0;
            bcnt <= '0;
          end
        end else begin
          acc  <= acc_nxt;
          bcnt <= bcnt + PARAM_W'(1);
          if (fin_rem) begin
            oMSB <= zcnt;
            oLSB <= acc_nxt;
            zcnt <= '0;
            bcnt <= '0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_rice_stream_reader.sv
// Directed bench for rice_stream_reader.
// Captures every done pulse and compares against hand-computed codewords.
module tb_rice_stream_reader;

  logic        iClock = 1'b0;
  logic        iReset = 1'b1;
  logic        iEnable = 1'b0;
  logic        iData = 1'b0;
  logic [3:0]  iRiceParam = 4'd3;
  logic [15:0] oMSB;
  logic [15:0] oLSB;
  logic        oDone;

  rice_stream_reader dut (
    .iClock     (iClock),
    .iReset     (iReset),
    .iEnable    (iEnable),
    .iData      (iData),
    .iRiceParam (iRiceParam),
    .oMSB       (oMSB),
    .oLSB       (oLSB),
    .oDone      (oDone)
  );

  always #5 iClock = ~iClock;

  int nchecks = 0;
  int nerrs = 0;
  int cyc = 0;
  int hold_err = 0;
  int dis_err = 0;
  logic en_q = 1'b0;
  logic rst_q = 1'b1;
  logic [15:0] last_m;
  logic [15:0] last_l;
  int gm[$];
  int gl[$];
  int gc[$];
  int em[$];
  int el[$];

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    nchecks++;
    if (got !== exp) begin
      nerrs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(posedge iClock) begin
    cyc++;
    en_q = iEnable;
    rst_q = iReset;
  end

  always @(negedge iClock) begin
    if (oDone) begin
      gm.push_back(int'(oMSB));
      gl.push_back(int'(oLSB));
      gc.push_back(cyc);
      if (!en_q || rst_q) dis_err++;
      last_m = oMSB;
      last_l = oLSB;
    end else if (!rst_q && (oMSB !== last_m || oLSB !== last_l)) begin
      hold_err++;
    end
    if (rst_q) begin
      last_m = oMSB;
      last_l = oLSB;
    end
  end

  task automatic send(logic b);
    @(negedge iClock);
    iEnable = 1'b1;
    iData = b;
  endtask

  task automatic send_str(string s);
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == "1") send(1'b1);
      else if (s[i] == "0") send(1'b0);
    end
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(negedge iClock);
      iEnable = 1'b0;
    end
  endtask

  task automatic expect_cw(int m, int l);
    em.push_back(m);
    el.push_back(l);
  endtask

  task automatic flush(string tag);
    idle(3);
    #1;
    check($sformatf("%s_count", tag), gm.size(), em.size());
    foreach (em[i]) begin
      if (i < gm.size()) begin
        check($sformatf("%s_msb%0d", tag, i), gm[i], em[i]);
        check($sformatf("%s_lsb%0d", tag, i), gl[i], el[i]);
      end
    end
    gm.delete();
    gl.delete();
    gc.delete();
    em.delete();
    el.delete();
  endtask

  initial begin
    int zz;
    int sv;
    repeat (2) @(negedge iClock);
    iReset = 1'b0;
    #1;
    check("rst_msb", oMSB, 0);
    check("rst_lsb", oLSB, 0);
    check("rst_done", oDone, 0);

    iRiceParam = 4'd3;
    send_str("000001 101");
    idle(1);
    #1;
    check("zz_count", gm.size(), 1);
    if (gm.size() > 0) begin
      zz = (gm[0] << 3) | gl[0];
      sv = zz[0] ? -((zz + 1) / 2) : zz / 2;
      check("zz_val", zz, 45);
      check("zz_signed", sv, -23);
    end
    send_str("001 110 1 010 000001 111 00000000000 1 001");
    expect_cw(5, 5);
    expect_cw(2, 6);
    expect_cw(0, 2);
    expect_cw(5, 7);
    expect_cw(11, 1);
    flush("k3");

    iRiceParam = 4'd0;
    send_str("1 01 0001 1 1");
    @(negedge iClock);
    iEnable = 1'b0;
    #1;
    if (gc.size() >= 2) check("k0_b2b", gc[$] - gc[$-1], 1);
    else check("k0_b2b_n", gc.size(), 2);
    expect_cw(0, 0);
    expect_cw(1, 0);
    expect_cw(3, 0);
    expect_cw(0, 0);
    expect_cw(0, 0);
    flush("k0");

    iRiceParam = 4'd15;
    send(1'b1);
    for (int i = 0; i < 15; i++) begin
      if (i == 5) iRiceParam = 4'd2;
      send(1'b1);
    end
    expect_cw(0, 32767);
    flush("k15");

    iRiceParam = 4'd3;
    send_str("00");
    idle(3);
    send_str("011");
    idle(3);
    send_str("01");
    expect_cw(3, 5);
    flush("en");

    send_str("000 1");
    @(negedge iClock);
    iReset = 1'b1;
    iEnable = 1'b1;
    iData = 1'b1;
    @(negedge iClock);
    iReset = 1'b0;
    iEnable = 1'b0;
    #1;
    check("mid_rst_msb", oMSB, 0);
    check("mid_rst_lsb", oLSB, 0);
    check("mid_rst_done", oDone, 0);
    send_str("01 011");
    expect_cw(1, 3);
    flush("rst");

    check("hold", hold_err, 0);
    check("done_disabled", dis_err, 0);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
    $finish;
  end

endmodule
